pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencing for a two-player pong game.
// Button inputs are synchronised and edge-detected, then an FSM steps
// through IDLE -> SERVE -> PLAY -> GAMEOVER and keeps the score.
// Optional feature macro: PONG_PAUSE_EN (pause button toggles PLAY/PAUSE).
//
// state    | code | meaning
// IDLE     | 0    | waiting for start, scores held at 0
// SERVE    | 1    | ball recentred, countdown before play
// PLAY     | 2    | ball and paddles moving, goals scored
// GAMEOVER | 3    | match won, scores and winner held
// PAUSE    | 4    | play frozen (only with PONG_PAUSE_EN)

// Two-flop synchroniser plus falling-edge detector for an active-low button.
// A button already held low when reset releases is not reported until it has
// been seen high at least once.
module pong_btn_edge (
    input  logic clk_0,
    input  logic rst,
    input  logic pin_n,
    output logic press
);
    logic s1, s2, s3;
    logic v1, v2, armed;

    // Synchroniser, edge history and arming once real high data has been seen.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            s3    <= 1'b1;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= pin_n;
            s2    <= s1;
            s3    <= s2;
            v1    <= 1'b1;
            v2    <= v1;
            armed <= armed | (v2 & s2);
        end
    end

    assign press = armed & s3 & ~s2;
endmodule

module pong_match_ctrl #(
    parameter int WIN_SCORE         = 7,
    parameter int SERVE_DELAY_TICKS = 25_175_000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       start_n,
    input  logic       pause_n,
    input  logic       goal_l,
    input  logic       goal_r,
    output logic       run,
    output logic       serve,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        GAMEOVER = 3'd3,
        PAUSE    = 3'd4
    } state_t;

    localparam logic [3:0]  WIN  = WIN_SCORE[3:0];
    localparam logic [24:0] LOAD = 25'(SERVE_DELAY_TICKS - 1);

    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [3:0]  p1_d, p2_d, p1_inc, p2_inc;
    logic [1:0]  winner_d;
    logic        dir_d, serve_d, run_d;
    logic        start_press, pause_press;

    pong_btn_edge u_start (
        .clk_0 (clk_0),
        .rst   (rst),
        .pin_n (start_n),
        .press (start_press)
    );

`ifdef PONG_PAUSE_EN
    pong_btn_edge u_pause (
        .clk_0 (clk_0),
        .rst   (rst),
        .pin_n (pause_n),
        .press (pause_press)
    );
`else
    wire unused_pause_n = pause_n;
    assign pause_press = 1'b0;
`endif

    assign p1_inc = score_p1 + 4'd1;
    assign p2_inc = score_p2 + 4'd1;

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p1_d     = score_p1;
        p2_d     = score_p2;
        winner_d = winner;
        dir_d    = serve_dir;
        serve_d  = 1'b0;
        case (state_q)
            IDLE: begin
                p1_d     = 4'd0;
                p2_d     = 4'd0;
                winner_d = 2'b00;
                if (start_press) begin
                    state_d = SERVE;
                    serve_d = 1'b1;
                    cnt_d   = LOAD;
                end
            end
            SERVE: begin
                if (cnt_q == '0) state_d = PLAY;
                else             cnt_d   = cnt_q - 25'd1;
            end
            PLAY: begin
                if (goal_l && goal_r) begin
                    state_d = SERVE;
                    serve_d = 1'b1;
                    cnt_d   = LOAD;
                end else if (goal_l) begin
                    p2_d  = p2_inc;
                    dir_d = 1'b0;
                    if (p2_inc == WIN) begin
                        state_d  = GAMEOVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = SERVE;
                        serve_d = 1'b1;
                        cnt_d   = LOAD;
                    end
                end else if (goal_r) begin
                    p1_d  = p1_inc;
                    dir_d = 1'b1;
                    if (p1_inc == WIN) begin
                        state_d  = GAMEOVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = SERVE;
                        serve_d = 1'b1;
                        cnt_d   = LOAD;
                    end
                end else if (pause_press) begin
                    state_d = PAUSE;
                end
            end
            GAMEOVER: begin
                if (start_press) begin
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = 2'b00;
                    dir_d    = 1'b0;
                    state_d  = SERVE;
                    serve_d  = 1'b1;
                    cnt_d    = LOAD;
                end
            end
`ifdef PONG_PAUSE_EN
            PAUSE: begin
                if (pause_press) state_d = PLAY;
            end
`endif
            default: state_d = IDLE;
        endcase
        run_d = (state_d == PLAY);
    end

    // State and registered outputs; reset wins over every event.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            winner    <= 2'b00;
            serve_dir <= 1'b0;
            serve     <= 1'b0;
            run       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_p1  <= p1_d;
            score_p2  <= p2_d;
            winner    <= winner_d;
            serve_dir <= dir_d;
            serve     <= serve_d;
            run       <= run_d;
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed testbench for pong_match_ctrl with WIN_SCORE = 3, SERVE_DELAY_TICKS = 4.
module tb_pong_match_ctrl;
    logic       clk_0 = 1'b0;
    logic       rst = 1'b0;
    logic       start_n = 1'b1;
    logic       pause_n = 1'b1;
    logic       goal_l = 1'b0;
    logic       goal_r = 1'b0;
    logic       run, serve, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    logic [15:0] e;

    pong_match_ctrl #(.WIN_SCORE(3), .SERVE_DELAY_TICKS(4)) dut (
        .clk_0     (clk_0),
        .rst       (rst),
        .start_n   (start_n),
        .pause_n   (pause_n),
        .goal_l    (goal_l),
        .goal_r    (goal_r),
        .run       (run),
        .serve     (serve),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .winner    (winner),
        .state     (state)
    );

    always #5 clk_0 = ~clk_0;

    wire [15:0] obs = {state, run, serve, serve_dir, score_p1, score_p2, winner};

    function automatic logic [15:0] ev(input logic [2:0] s, input logic r, input logic sv,
                                       input logic d, input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] w);
        return {s, r, sv, d, a, b, w};
    endfunction

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic press_start();
        start_n = 1'b0;
        repeat (3) tick();
        start_n = 1'b1;
    endtask

    task automatic press_pause();
        pause_n = 1'b0;
        repeat (3) tick();
        pause_n = 1'b1;
    endtask

    task automatic wait_play(input string name);
        int n = 0;
        while (state !== 3'd2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL %s timeout state=%0d expected=2", name, state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_n = 1'b0;
        repeat (2) tick();
        e = ev(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_values got=%h exp=%h", obs, e); end
        rst = 1'b1;
        repeat (10) tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL held_start_no_press got=%h exp=%h", obs, e); end
        start_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_start();
        press_start();
        e = ev(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL start_serve_pulse got=%h exp=%h", obs, e); end
        e = ev(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL serve_hold_%0d got=%h exp=%h", i, obs, e); end
        end
        tick();
        e = ev(2, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL enter_play got=%h exp=%h", obs, e); end
    endtask

    task automatic test_goal_r();
        goal_r = 1'b1;
        tick();
        goal_r = 1'b0;
        e = ev(1, 0, 1, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL goal_r got=%h exp=%h", obs, e); end
        wait_play("goal_r_replay");
        e = ev(2, 1, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL goal_r_play got=%h exp=%h", obs, e); end
    endtask

    task automatic test_double_goal();
        goal_l = 1'b1;
        goal_r = 1'b1;
        tick();
        goal_l = 1'b0;
        goal_r = 1'b0;
        e = ev(1, 0, 1, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL double_goal got=%h exp=%h", obs, e); end
        tick();
        goal_l = 1'b1;
        tick();
        goal_l = 1'b0;
        e = ev(1, 0, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL goal_in_serve got=%h exp=%h", obs, e); end
        wait_play("double_goal_replay");
    endtask

    task automatic test_win();
        for (int i = 1; i <= 2; i++) begin
            goal_l = 1'b1;
            tick();
            goal_l = 1'b0;
            e = ev(1, 0, 1, 0, 1, 4'(i), 0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL goal_l_%0d got=%h exp=%h", i, obs, e); end
            wait_play("goal_l_replay");
        end
        goal_l = 1'b1;
        tick();
        goal_l = 1'b0;
        e = ev(3, 0, 0, 0, 1, 3, 2);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL win_p2 got=%h exp=%h", obs, e); end
        goal_r = 1'b1;
        tick();
        goal_r = 1'b0;
        tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL gameover_hold got=%h exp=%h", obs, e); end
        press_start();
        e = ev(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL restart got=%h exp=%h", obs, e); end
        wait_play("restart_play");
    endtask

    task automatic test_pause();
        press_pause();
`ifdef PONG_PAUSE_EN
        e = ev(4, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pause_enter got=%h exp=%h", obs, e); end
        goal_l = 1'b1;
        tick();
        goal_l = 1'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pause_goal_ignored got=%h exp=%h", obs, e); end
`else
        e = ev(2, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pause_ignored got=%h exp=%h", obs, e); end
`endif
        repeat (4) tick();
        press_pause();
        e = ev(2, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pause_exit got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_mid_serve();
        goal_r = 1'b1;
        tick();
        goal_r = 1'b0;
        e = ev(1, 0, 1, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pre_reset_serve got=%h exp=%h", obs, e); end
        tick();
        rst = 1'b0;
        tick();
        e = ev(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_mid_serve got=%h exp=%h", obs, e); end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL idle_after_reset got=%h exp=%h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_goal_r();
        test_double_goal();
        test_win();
        test_pause();
        test_reset_mid_serve();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
